crc_byte_accumulator: RTL and testbench
=======================================

// Module: crc_byte_accumulator
// PURPOSE
//  Byte-serial front end for the CRC datapath. It collects 1..8 bytes from the 8-bit input
//  bus into a 64-bit little-byte-order word, then presents that word with a zero-based byte
//  count. The word and count drive the combinational per-byte reflector and CRC core
//  directly downstream. Valid/ready handshakes are used on both sides.
// PARAMETERS
//  MAX_BYTES  8  bytes per word before a forced flush; legal range 1..8
//  BYTE_W     8  input byte width; fixed at 8, no other value supported
// PORTS
//  clk            input   1   system clock; all logic is rising-edge
//  reset          input   1   synchronous, active-high reset
//  in_valid       input   1   in_byte is valid this cycle
//  in_byte        input   8   data byte
//  in_last        input   1   qualified by in_valid; this byte closes the word
//  in_ready       output  1   accumulator accepts a byte this cycle
//  out_valid      output  1   out_value/out_bytewidth hold a complete word
//  out_ready      input   1   downstream consumes the word this cycle
//  out_value      output  64  byte k in bits [8k+7:8k]; unfilled bytes are 0
//  out_bytewidth  output  3   bytes held minus 1 (0 = 1 byte, 7 = 8 bytes)
// BEHAVIOUR
//  - State: FILL or HOLD; cnt[3:0] holds 0..MAX_BYTES; data register is 64 bits.
//  - Reset (sampled on clk):
//    - state=FILL, cnt=0, data=0
//    - out_valid=0, out_value=0, out_bytewidth=0, in_ready=1
//    - Reset asserted mid-word or while out_valid=1 discards the word; no output is emitted.
//  - FILL:
//    - in_ready=1, out_valid=0.
//    - Accept on in_valid: data[8*cnt +: 8] <= in_byte; cnt <= cnt+1.
//    - If in_last=1 or cnt+1==MAX_BYTES: enter HOLD on the next edge.
//  - HOLD:
//    - out_valid=1; out_value=data; out_bytewidth=cnt-1 (registered, not computed from inputs).
//    - in_ready=0 in base build.
//    - out_valid stays 1 and outputs stay stable until out_ready=1 (no retraction).
//    - Transfer on out_valid & out_ready: data<=0, cnt<=0, state<=FILL.
//  - Latency: the last accepted byte appears at out_valid on the next cycle.
//  - Maximum throughput in base build: one word per (N bytes + 1) cycles.
//  - Boundaries:
//    - in_last on byte 1 gives out_bytewidth=0.
//    - The 8th byte without in_last forces a flush with out_bytewidth=7.
//    - in_last on the MAX_BYTES-th byte is a single flush, not two.
//    - in_valid=0 cycles in FILL hold all state; there is no timeout.
//    - in_last while in_valid=0 is ignored.
//    - An empty word (cnt=0) is never emitted.
// CONFIGURATION
//  CRC_ACC_BACK2BACK_EN
//    Defined:
//     - In HOLD, in_ready = out_ready.
//     - A byte accepted on the same edge as the output transfer is loaded as byte 0 of a
//       fresh word: data={56'b0,in_byte}, cnt=1.
//     - After that edge: state=FILL, or HOLD with out_bytewidth=0 if in_last=1 (or
//       MAX_BYTES==1).
//     - Gives one byte per cycle sustained throughput.
//    Undefined:
//     - in_ready=0 throughout HOLD; base behaviour above applies.
// TESTING
//  1. Reset, feed 0x11,0x22,0x33 (last on 0x33), out_ready=1
//     -> out_value=64'h332211, bytewidth=2, out_valid for 1 cycle.
//  2. Feed 0x01..0x08 with in_last=0
//     -> forced flush: out_value=64'h0807060504030201, bytewidth=7; in_ready=0 while held.
//  3. Single byte 0xA5 with in_last; out_ready low 5 cycles
//     -> out_valid held 5 cycles, value 0xA5, bytewidth 0, stable; then clears on transfer.
//  4. Feed 0xDE,0xAD, assert reset, then feed 0xBE with in_last
//     -> out_value=0xBE, bytewidth=0 (no residue from before reset).
//  5. Random in_valid/out_ready gaps, 200 words of random length 1..8
//     -> scoreboard matches every word/bytewidth in order; no drops or duplicates.
//  6. CRC_ACC_BACK2BACK_EN defined: continuous in_valid, in_last every 2nd byte, out_ready=1
//     -> in_ready stays 1, a word is emitted every 2 cycles, bytewidth=1 each.

Source files
------------

// File: rtl/crc_byte_accumulator.sv
// Byte-serial accumulator feeding the CRC datapath: packs 1..MAX_BYTES bytes into a
// little-byte-order 64-bit word plus a zero-based byte count. Optional macro: CRC_ACC_BACK2BACK_EN.
module crc_byte_accumulator #(
    parameter int MAX_BYTES = 8,
    parameter int BYTE_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_value,
    output logic [2:0]        out_bytewidth,
    output logic              dbg_state_o
);

    // Handshakes: a beat moves when valid & ready are both high on a rising edge;
    // out_valid is never withdrawn and out_value/out_bytewidth hold until that beat.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BYTES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            cnt_q   <= 4'd0;
            data_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    data_d[{cnt_q[2:0], 3'b000} +: BYTE_W] = in_byte;
                    cnt_d = cnt_q + 4'd1;
                    if (in_last || (cnt_d == MAX_CNT)) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = FILL;
                    cnt_d   = 4'd0;
                    data_d  = 64'd0;
`ifdef CRC_ACC_BACK2BACK_EN
                    // The byte arriving on the transfer edge starts the next word.
                    if (in_valid) begin
                        data_d = {{(64-BYTE_W){1'b0}}, in_byte};
                        cnt_d  = 4'd1;
                        if (in_last || (MAX_CNT == 4'd1)) begin
                            state_d = HOLD;
                        end
                    end
`endif
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready      = 1'b1;
        out_valid     = 1'b0;
        out_value     = 64'd0;
        out_bytewidth = 3'd0;
        dbg_state_o   = state_q;
        if (state_q == HOLD) begin
            out_valid     = 1'b1;
            out_value     = data_q;
            // A full 8-byte word has cnt=8, whose low bits wrap to 7 after the decrement.
            out_bytewidth = cnt_q[2:0] - 3'd1;
`ifdef CRC_ACC_BACK2BACK_EN
            in_ready      = out_ready;
`else
            in_ready      = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_crc_byte_accumulator.sv
// Bench for crc_byte_accumulator: directed scenarios plus randomized traffic scored
// against a byte-queue reference model. Honors CRC_ACC_BACK2BACK_EN when defined.
module tb_crc_byte_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_value;
    logic [2:0]  out_bytewidth;
    logic        dbg_state;

    int checks = 0;
    int errors = 0;

    logic [66:0] exp_q[$];
    logic [7:0]  cur_q[$];

    logic        obs_in_ready, obs_out_valid, obs_acc, obs_xfer;
    logic [63:0] obs_value;
    logic [2:0]  obs_bw;

    always #5 clk = ~clk;

    crc_byte_accumulator dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_byte       (in_byte),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_value     (out_value),
        .out_bytewidth (out_bytewidth),
        .dbg_state_o   (dbg_state)
    );

    task automatic apply_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cur_q.delete();
        exp_q.delete();
    endtask

    // Drives one cycle, samples mid-cycle, and advances the reference model.
    task automatic drive_cycle(input logic v, input logic [7:0] b, input logic l,
                               input logic ordy);
        logic [63:0] w;
        in_valid  = v;
        in_byte   = b;
        in_last   = l;
        out_ready = ordy;
        #4;
        obs_in_ready  = in_ready;
        obs_out_valid = out_valid;
        obs_value     = out_value;
        obs_bw        = out_bytewidth;
        obs_acc       = v && in_ready;
        obs_xfer      = out_valid && ordy;
        if (obs_acc) begin
            cur_q.push_back(b);
            if (l || cur_q.size() == 8) begin
                w = 64'd0;
                for (int k = 0; k < cur_q.size(); k++) begin
                    w = w + (64'(cur_q[k]) << (8 * k));
                end
                exp_q.push_back({3'(cur_q.size() - 1), w});
                cur_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (out_valid !== 1'b0 || out_value !== 64'd0 || out_bytewidth !== 3'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid=%b value=%h bw=%0d rdy=%b want 0/0/0/1",
                     out_valid, out_value, out_bytewidth, in_ready);
        end
    endtask

    task automatic test_three_bytes();
        apply_reset();
        drive_cycle(1'b1, 8'h11, 1'b0, 1'b1);
        drive_cycle(1'b1, 8'h22, 1'b0, 1'b1);
        drive_cycle(1'b1, 8'h33, 1'b1, 1'b1);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (obs_out_valid !== 1'b1 || obs_value !== 64'h332211 || obs_bw !== 3'd2) begin
            errors++;
            $display("FAIL three_bytes: valid=%b value=%h bw=%0d want 1/332211/2",
                     obs_out_valid, obs_value, obs_bw);
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (obs_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL three_bytes_one_cycle: valid=%b want 0", obs_out_valid);
        end
    endtask

    task automatic test_forced_flush();
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
        end
        drive_cycle(1'b1, 8'h99, 1'b0, 1'b0);
        checks++;
        if (obs_out_valid !== 1'b1 || obs_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_hold: valid=%b rdy=%b want 1/0", obs_out_valid, obs_in_ready);
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (obs_value !== 64'h0807060504030201 || obs_bw !== 3'd7) begin
            errors++;
            $display("FAIL flush_word: value=%h bw=%0d want 0807060504030201/7", obs_value, obs_bw);
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (obs_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_single: valid=%b want 0", obs_out_valid);
        end
    endtask

    task automatic test_hold_stall();
        apply_reset();
        drive_cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
            checks++;
            if (obs_out_valid !== 1'b1 || obs_value !== 64'hA5 || obs_bw !== 3'd0) begin
                errors++;
                $display("FAIL stall_%0d: valid=%b value=%h bw=%0d want 1/a5/0",
                         i, obs_out_valid, obs_value, obs_bw);
            end
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (obs_out_valid !== 1'b1 || obs_value !== 64'hA5) begin
            errors++;
            $display("FAIL stall_xfer: valid=%b value=%h want 1/a5", obs_out_valid, obs_value);
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (obs_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_clear: valid=%b want 0", obs_out_valid);
        end
    endtask

    task automatic test_reset_mid_word();
        apply_reset();
        drive_cycle(1'b1, 8'hDE, 1'b0, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        drive_cycle(1'b1, 8'hAD, 1'b0, 1'b0);
        checks++;
        if (obs_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_last_ignored: valid=%b want 0", obs_out_valid);
        end
        apply_reset();
        drive_cycle(1'b1, 8'hBE, 1'b1, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (obs_out_valid !== 1'b1 || obs_value !== 64'hBE || obs_bw !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_word: valid=%b value=%h bw=%0d want 1/be/0",
                     obs_out_valid, obs_value, obs_bw);
        end
    endtask

    task automatic test_random();
        int          len, idx, sent, got;
        logic        v, l, ordy, exp_rdy, prev_hold;
        logic [63:0] prev_val;
        logic [2:0]  prev_bw;
        logic [66:0] exp;
        apply_reset();
        len = $urandom_range(1, 8);
        idx = 0; sent = 0; got = 0; prev_hold = 1'b0;
        prev_val = 64'd0; prev_bw = 3'd0;
        for (int cyc = 0; cyc < 20000 && got < 200; cyc++) begin
            v = (sent < 200) && ($urandom_range(0, 3) != 0);
            if (v) l = (idx == len - 1) ? ((len == 8) ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
            else   l = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 2) != 0);
            drive_cycle(v, 8'($urandom), l, ordy);
`ifdef CRC_ACC_BACK2BACK_EN
            exp_rdy = obs_out_valid ? ordy : 1'b1;
`else
            exp_rdy = !obs_out_valid;
`endif
            checks++;
            if (obs_in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_in_ready cyc %0d: got %b want %b", cyc, obs_in_ready, exp_rdy);
            end
            if (prev_hold) begin
                checks++;
                if (obs_out_valid !== 1'b1 || obs_value !== prev_val || obs_bw !== prev_bw) begin
                    errors++;
                    $display("FAIL rand_stable cyc %0d: valid=%b value=%h bw=%0d want 1/%h/%0d",
                             cyc, obs_out_valid, obs_value, obs_bw, prev_val, prev_bw);
                end
            end
            if (obs_xfer) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious cyc %0d: value=%h bw=%0d with nothing expected",
                             cyc, obs_value, obs_bw);
                end else begin
                    exp = exp_q.pop_front();
                    if ({obs_bw, obs_value} !== exp) begin
                        errors++;
                        $display("FAIL rand_word %0d: value=%h bw=%0d want %h/%0d",
                                 got, obs_value, obs_bw, exp[63:0], exp[66:64]);
                    end
                end
                got++;
            end
            prev_hold = obs_out_valid && !ordy;
            prev_val  = obs_value;
            prev_bw   = obs_bw;
            if (obs_acc) begin
                idx++;
                if (idx == len) begin
                    sent++;
                    idx = 0;
                    len = $urandom_range(1, 8);
                end
            end
        end
        checks++;
        if (got != 200 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_count: got %0d words, %0d left over, want 200/0", got, exp_q.size());
        end
    endtask

`ifdef CRC_ACC_BACK2BACK_EN
    task automatic test_back_to_back();
        int          last_x, nx;
        logic [66:0] exp;
        apply_reset();
        last_x = -1; nx = 0;
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) drive_cycle(1'b1, 8'($urandom), 1'(i % 2), 1'b1);
            else        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
            if (i < 20) begin
                checks++;
                if (obs_in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready cyc %0d: got %b want 1", i, obs_in_ready);
                end
            end
            if (obs_xfer) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 67'd0;
                checks++;
                if (obs_bw !== 3'd1 || obs_value !== exp[63:0] || (last_x >= 0 && i - last_x != 2)) begin
                    errors++;
                    $display("FAIL b2b_word cyc %0d: value=%h bw=%0d gap=%0d want %h/1/2",
                             i, obs_value, obs_bw, i - last_x, exp[63:0]);
                end
                last_x = i;
                nx++;
            end
        end
        checks++;
        if (nx != 10) begin
            errors++;
            $display("FAIL b2b_count: got %0d words want 10", nx);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_three_bytes();
        test_forced_flush();
        test_hold_stall();
        test_reset_mid_word();
        test_random();
`ifdef CRC_ACC_BACK2BACK_EN
        test_back_to_back();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
